// File: rtl/syn_input_scheduler.sv
// Round-robin scheduler that shares the neuron's synaptic-current input among NUM_REQ requesters,
// accumulating granted weights with saturation over a frame and committing the sum on a tick.
module syn_input_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int W           = 8,
    parameter int TICK_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] weight,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [W-1:0]         i_syn,
    output logic                 tick,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int CW = $clog2(TICK_PERIOD);
    localparam int PW = $clog2(NUM_REQ);

    // state  | meaning
    // IDLE   | scheduler disabled, no grants
    // ACCUM  | one grant slot per cycle, weights summed into acc
    // COMMIT | frame end: acc moves to i_syn and tick fires
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   i_syn_q, i_syn_d;
    logic           tick_q, tick_d;
    logic           ovf_q, ovf_d;

    logic           found;
    logic [PW-1:0]  gidx;
    int             srch_idx;
    logic [W-1:0]   wsel;
    logic [W:0]     sum;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        srch_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            srch_idx = int'(ptr_q) + i;
            if (srch_idx >= NUM_REQ) srch_idx = srch_idx - NUM_REQ;
            if (!found && req[PW'(srch_idx)]) begin
                found = 1'b1;
                gidx  = PW'(srch_idx);
            end
        end
    end

    assign wsel = weight[int'(gidx)*W +: W];
    assign sum  = {1'b0, acc_q} + {1'b0, wsel};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        i_syn_d = i_syn_q;
        tick_d  = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;
        gnt     = '0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                // The grant is visible even when en drops; it is simply not applied.
                if (found) gnt[gidx] = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    if (found) begin
                        if (sum[W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[W-1:0];
                        end
                        ptr_d = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TICK_PERIOD-2)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                acc_d = '0;
                cnt_d = '0;
                if (en) begin
                    i_syn_d = acc_q;
                    tick_d  = 1'b1;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ptr_q   <= '0;
            i_syn_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            i_syn_q <= i_syn_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    assign i_syn = i_syn_q;
    assign tick  = tick_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_syn_input_scheduler.sv
// Bench for syn_input_scheduler: directed scenarios plus random traffic against a frame-level
// behavioural model of grants, accumulation, commits and the sticky overflow flag.
module tb_syn_input_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TP  = 16;
    localparam int MAXV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req;
    logic [N*W-1:0]   weight;
    logic [N-1:0]     gnt;
    logic [W-1:0]     i_syn;
    logic             tick;
    logic             ovf;
    logic             clr_ovf;

    always #5 clk = ~clk;

    syn_input_scheduler #(.NUM_REQ(N), .W(W), .TICK_PERIOD(TP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .weight  (weight),
        .gnt     (gnt),
        .i_syn   (i_syn),
        .tick    (tick),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: running flag, slot within frame (TP-1 = commit slot), sums as plain ints.
    bit m_run;
    int m_slot, m_acc, m_ptr, m_isyn, m_tick, m_ovf;
    int last_gnt_obs;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_slot = 0; m_acc = 0; m_ptr = 0;
        m_isyn = 0; m_tick = 0; m_ovf = 0;
    endtask

    function automatic int exp_gnt_idx();
        if (!m_run || m_slot == TP-1) return -1;
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic cycle(input bit e, input logic [N-1:0] r, input logic [N*W-1:0] wv, input bit c);
        int k;
        int s;
        int nt;
        int novf;
        @(negedge clk);
        check_val("tick", int'(tick), m_tick);
        check_val("i_syn", int'(i_syn), m_isyn);
        check_val("ovf", int'(ovf), m_ovf);
        en = e; req = r; weight = wv; clr_ovf = c;
        #1;
        k = exp_gnt_idx();
        last_gnt_obs = int'(gnt);
        check_val("gnt", int'(gnt), (k < 0) ? 0 : (1 << k));
        @(posedge clk);
        nt = 0;
        novf = c ? 0 : m_ovf;
        if (!m_run) begin
            if (e) begin m_run = 1; m_slot = 0; m_acc = 0; end
        end else if (!e) begin
            m_run = 0; m_acc = 0; m_slot = 0;
        end else if (m_slot < TP-1) begin
            if (k >= 0) begin
                s = m_acc + int'(wv[k*W +: W]);
                if (s > MAXV) begin m_acc = MAXV; novf = 1; end
                else m_acc = s;
                m_ptr = (k + 1) % N;
            end
            m_slot++;
        end else begin
            m_isyn = m_acc; m_acc = 0; m_slot = 0; nt = 1;
        end
        m_tick = nt;
        m_ovf = novf;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        #2 rst_n = 1'b1;
        #1;
        check_val("rst_i_syn", int'(i_syn), 0);
        check_val("rst_tick", int'(tick), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_gnt", int'(gnt), 0);
        model_reset();
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
    endtask

    logic [N*W-1:0] w;
    int guard;

    initial begin
        rst_n = 1'b1; en = 1'b0; req = '0; weight = '0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("init_i_syn", int'(i_syn), 0);
        check_val("init_tick", int'(tick), 0);
        check_val("init_ovf", int'(ovf), 0);
        rst_n = 1'b0;

        // Single requester, weight 10: 15 grants per frame -> 150.
        w = {8'd0, 8'd0, 8'd0, 8'd10};
        repeat (1 + 3*TP) cycle(1, 4'b0001, w, 0);
        check_val("single_isyn", int'(i_syn), 150);

        // Drop enable at cnt=7 (acc=70): no tick, i_syn holds 150.
        guard = 0;
        while (!(m_run && m_slot == 7) && guard < 40) begin
            cycle(1, 4'b0001, w, 0);
            guard++;
        end
        check_val("en_reach_cnt7", guard < 40 ? 1 : 0, 1);
        cycle(0, 4'b0001, w, 0);
        repeat (3) cycle(0, 4'b0001, w, 0);
        check_val("en_hold_isyn", int'(i_syn), 150);
        repeat (1 + TP + 5) cycle(1, 4'b0001, w, 0);

        // Reset mid-frame with a nonzero accumulator and committed value.
        do_reset();

        // Round robin 1,2,3,4 from ptr=0 -> 36, next frame begins at requester 3.
        w = {8'd4, 8'd3, 8'd2, 8'd1};
        cycle(1, 4'b1111, w, 0);
        for (int i = 0; i < TP-1; i++) begin
            cycle(1, 4'b1111, w, 0);
            check_val("rr_order", last_gnt_obs, 1 << (i % N));
        end
        cycle(1, 4'b1111, w, 0);
        #1 check_val("rr_isyn", int'(i_syn), 36);
        cycle(1, 4'b1111, w, 0);
        check_val("rr_next", last_gnt_obs, 8);
        repeat (TP) cycle(1, 4'b1111, w, 0);

        // Sparse requests: after granting 1, a new req0 still loses to 3.
        w = {8'd5, 8'd5, 8'd5, 8'd5};
        guard = 0;
        do begin
            cycle(1, 4'b1010, w, 0);
            guard++;
        end while (!(last_gnt_obs == 2 && m_run && m_slot < TP-1) && guard < 40);
        check_val("sparse_reach", guard < 40 ? 1 : 0, 1);
        cycle(1, 4'b1011, w, 0);
        check_val("sparse_3_first", last_gnt_obs, 8);
        if (m_slot < TP-1) begin
            cycle(1, 4'b1011, w, 0);
            check_val("sparse_0_next", last_gnt_obs, 1);
        end
        repeat (TP) cycle(1, 4'b1010, w, 0);

        // Saturation and the sticky flag.
        do_reset();
        w = {8'd0, 8'd0, 8'd0, 8'd200};
        cycle(1, 4'b0001, w, 0);
        cycle(1, 4'b0001, w, 0);
        cycle(1, 4'b0001, w, 0);
        #1 check_val("sat_ovf_set", int'(ovf), 1);
        cycle(1, 4'b0001, w, 1);
        #1 check_val("sat_set_wins", int'(ovf), 1);
        cycle(1, 4'b0000, w, 1);
        #1 check_val("sat_clr", int'(ovf), 0);
        guard = 0;
        while (!tick && guard < 40) begin
            cycle(1, 4'b0000, w, 0);
            #1;
            guard++;
        end
        check_val("sat_tick_seen", int'(tick), 1);
        check_val("sat_isyn", int'(i_syn), MAXV);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [N*W-1:0] rw;
            rw = N*W'($urandom());
            if ($urandom_range(0, 2) != 0) rw = rw & 32'h1f1f1f1f;
            cycle($urandom_range(0, 15) != 0, N'($urandom()), rw, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/syn_input_scheduler.md
Name: syn_input_scheduler

Overview:
- Time-multiplexes the shared synaptic-current input of the neuron datapath (8-bit I_syn in, membrane potential V_mem out) among NUM_REQ synapse requesters.
- Round-robin grants one requester per cycle and accumulates its weight with saturation over a fixed frame.
- At frame end, commits the sum to the neuron's I_syn input and pulses an update strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 8, weight / accumulator / i_syn width.
- TICK_PERIOD, 16, frame length in clock cycles (>=2); TICK_PERIOD-1 grant slots per frame.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset (1 = reset, despite the name).
- en  input  1  scheduler enable.
- req  input  NUM_REQ  per-requester request, level.
- weight  input  NUM_REQ*W  flattened weights; requester k uses bits [k*W +: W], unsigned.
- gnt  output  NUM_REQ  one-hot grant, combinational, at most one bit set.
- i_syn  output  W  committed synaptic current to the neuron datapath, registered.
- tick  output  1  one-cycle neuron-update strobe, registered.
- ovf  output  1  sticky saturation flag, registered.
- clr_ovf  input  1  clears ovf.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, acc=0, ptr=0, i_syn=0, tick=0, ovf=0. gnt=0 while in IDLE.
- IDLE: gnt=0. en=1 -> ACCUM with cnt=0. en=0 -> stay in IDLE.
- ACCUM:
  - gnt = first set req bit searching ptr, ptr+1, ... mod NUM_REQ.
  - On the edge: acc <= sat(acc + weight[granted]). Then ptr <= granted+1 mod NUM_REQ.
  - No req set: gnt=0, acc and ptr unchanged.
  - cnt increments each cycle. At cnt==TICK_PERIOD-2 -> COMMIT.
- COMMIT (cnt==TICK_PERIOD-1):
  - gnt=0.
  - On the edge: i_syn <= acc, acc <= 0, cnt <= 0, tick <= 1 for exactly the next cycle.
  - Next state ACCUM; IDLE if en=0.
  - The new i_syn and tick appear in the same cycle. tick period = TICK_PERIOD cycles.
- i_syn holds its value between commits.
- Saturation:
  - Sum computed in W+1 bits. Result > 2^W-1 clamps acc to 2^W-1 and sets ovf.
  - A grant landing at saturation keeps acc=2^W-1 and sets ovf again.
- ovf:
  - Cleared by clr_ovf on the edge.
  - Set and clear in the same cycle: set wins.
- en=0 in ACCUM/COMMIT:
  - On the next edge go to IDLE, acc<=0, cnt<=0, no tick.
  - i_syn retains its last committed value. ptr is retained.
  - gnt is still driven during the en=0 cycle, and that grant is discarded.
- Requesters see gnt in the same cycle and may change req/weight only after the edge.
- Reset mid-frame: everything returns to reset values immediately and a pending tick is lost.

Test Plan:
1. Reset: assert rst_n mid-frame with acc=50 and i_syn=30 -> i_syn=0, tick=0, ovf=0 and gnt=0 without a clock edge. After release with en=1, first tick arrives 16 cycles later.
2. Single requester: req=0001, weight0=10, TICK_PERIOD=16 -> 15 grants per frame, i_syn=150 at each tick, tick exactly every 16 cycles, gnt=0 in COMMIT.
3. Round robin: req=1111, weights 1,2,3,4, ptr=0 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3,0,1,2 -> i_syn=36. Next frame starts at requester 3.
4. Sparse requests: req=1010, weights 5 -> grants alternate 1,3,1,3. Inject req0 while ptr=2 -> grant goes to 3 before 0.
5. Saturation: req0 weight=200 -> acc=200 then 255 and ovf=1, i_syn=255. clr_ovf together with a saturating grant -> ovf stays 1. clr_ovf alone -> ovf=0.
6. Enable: drop en at cnt=7 with acc=70 -> IDLE, no tick, i_syn keeps previous 150. Re-raise en -> new frame from cnt=0 with acc=0.
